// File: rtl/hazard_scoreboard.sv
// Producer-side hazard tracker. It records the destinations of issued instructions and drives
// the ID-stage stall for load-use, early-branch and HI/LO hazards.
module hazard_scoreboard #(
    parameter int MULT_LAT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_flush,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_reg_write,
    input  logic [4:0]       id_dest,
    input  logic             id_is_load,
    input  logic             id_is_muldiv,
    input  logic             id_reads_hilo,
    output logic             stall,
    output logic [1:0]       stall_cause,
    output logic [31:0]      pending_mask,
    output logic [CNT_W-1:0] stall_count
);

    localparam int HW = $clog2(MULT_LAT + 1);

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_LOAD   = 2'b01;
    localparam logic [1:0] CAUSE_BRANCH = 2'b10;
    localparam logic [1:0] CAUSE_HILO   = 2'b11;

    logic [1:0]    ex_cnt [1:31];
    logic [1:0]    id_cnt [1:31];
    logic [HW-1:0] hilo_cnt;

    logic [31:0] ex_busy;
    logic [31:0] id_busy;
    logic        active;
    logic        issue;
    logic        rs_hit;
    logic        rt_hit;
    logic        hilo_busy;
    logic        haz_hilo;
    logic        haz_branch;
    logic        haz_load;

    always_comb begin
        ex_busy = '0;
        id_busy = '0;
        for (int r = 1; r < 32; r++) begin
            ex_busy[r] = (ex_cnt[r] != 2'd0);
            id_busy[r] = (id_cnt[r] != 2'd0);
        end
    end

    assign pending_mask = ex_busy | id_busy;

    // HI/LO becomes readable MULT_LAT cycles after the mult/div sat in ID, so the
    // final count value of 1 no longer blocks a reader.
    assign hilo_busy  = (hilo_cnt > HW'(1));

    assign active     = id_valid & ~id_flush;
    assign rs_hit     = id_uses_rs & (id_rs != 5'd0);
    assign rt_hit     = id_uses_rt & (id_rt != 5'd0);
    assign haz_hilo   = active & (id_reads_hilo | id_is_muldiv) & hilo_busy;
    assign haz_branch = active & id_is_branch
                      & ((rs_hit & id_busy[id_rs]) | (rt_hit & id_busy[id_rt]));
    assign haz_load   = active & ~id_is_branch
                      & ((rs_hit & ex_busy[id_rs]) | (rt_hit & ex_busy[id_rt]));

    always_comb begin
        stall_cause = CAUSE_NONE;
        if (haz_hilo) begin
            stall_cause = CAUSE_HILO;
        end else if (haz_branch) begin
            stall_cause = CAUSE_BRANCH;
        end else if (haz_load) begin
            stall_cause = CAUSE_LOAD;
        end
    end

    assign stall = (stall_cause != CAUSE_NONE);
    assign issue = active & ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < 32; r++) begin
                ex_cnt[r] <= 2'd0;
                id_cnt[r] <= 2'd0;
            end
            hilo_cnt    <= '0;
            stall_count <= '0;
        end else begin
            // Age every entry first; a same-edge issue to the same register overrides it.
            for (int r = 1; r < 32; r++) begin
                if (issue && id_reg_write && (id_dest == 5'(r))) begin
                    ex_cnt[r] <= id_is_load ? 2'd1 : 2'd0;
                    id_cnt[r] <= 2'd2;
                end else begin
                    ex_cnt[r] <= (ex_cnt[r] != 2'd0) ? ex_cnt[r] - 2'd1 : 2'd0;
                    id_cnt[r] <= (id_cnt[r] != 2'd0) ? id_cnt[r] - 2'd1 : 2'd0;
                end
            end

            if (issue && id_is_muldiv) begin
                hilo_cnt <= HW'(MULT_LAT);
            end else if (hilo_cnt != '0) begin
                hilo_cnt <= hilo_cnt - HW'(1);
            end

            if (stall && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench for hazard_scoreboard: a cycle-timeline model predicts every cycle's outputs
// into a queue that an independent negedge monitor drains and compares.
module tb_hazard_scoreboard;

    localparam int MULT_LAT = 4;
    localparam int CNT_W    = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_flush;
    logic [4:0]       id_rs, id_rt, id_dest;
    logic             id_uses_rs, id_uses_rt, id_is_branch, id_reg_write;
    logic             id_is_load, id_is_muldiv, id_reads_hilo;
    logic             stall;
    logic [1:0]       stall_cause;
    logic [31:0]      pending_mask;
    logic [CNT_W-1:0] stall_count;

    hazard_scoreboard #(.MULT_LAT(MULT_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_flush(id_flush),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_reg_write(id_reg_write),
        .id_dest(id_dest), .id_is_load(id_is_load),
        .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
        .stall(stall), .stall_cause(stall_cause),
        .pending_mask(pending_mask), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v, fl;
        logic [4:0] rs, rt;
        logic us, ut, br, rw;
        logic [4:0] dst;
        logic ld, md, rh;
    } ins_t;

    typedef struct {
        logic        stall;
        logic [1:0]  cause;
        logic [31:0] mask;
        int          count;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: absolute cycle at which each result becomes reachable by each path.
    longint k = 0;
    longint ex_ready [32];
    longint id_ready [32];
    longint hilo_ready = 0;
    int     cnt_model = 0;

    function automatic ins_t f_nop();
        ins_t i = '{default: '0};
        return i;
    endfunction
    function automatic ins_t f_alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        ins_t i = f_nop();
        i.v = 1; i.rs = s; i.rt = t; i.us = 1; i.ut = 1; i.rw = 1; i.dst = d;
        return i;
    endfunction
    function automatic ins_t f_lw(input logic [4:0] d, input logic [4:0] b);
        ins_t i = f_nop();
        i.v = 1; i.rs = b; i.us = 1; i.rw = 1; i.dst = d; i.ld = 1;
        return i;
    endfunction
    function automatic ins_t f_beq(input logic [4:0] s, input logic [4:0] t);
        ins_t i = f_nop();
        i.v = 1; i.rs = s; i.rt = t; i.us = 1; i.ut = 1; i.br = 1;
        return i;
    endfunction
    function automatic ins_t f_sw(input logic [4:0] b, input logic [4:0] t);
        ins_t i = f_nop();
        i.v = 1; i.rs = b; i.rt = t; i.us = 1; i.ut = 1;
        return i;
    endfunction
    function automatic ins_t f_mult(input logic [4:0] s, input logic [4:0] t);
        ins_t i = f_nop();
        i.v = 1; i.rs = s; i.rt = t; i.us = 1; i.ut = 1; i.md = 1;
        return i;
    endfunction
    function automatic ins_t f_mflo(input logic [4:0] d);
        ins_t i = f_nop();
        i.v = 1; i.rw = 1; i.dst = d; i.rh = 1;
        return i;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) begin
            ex_ready[r] = 0;
            id_ready[r] = 0;
        end
        hilo_ready = 0;
        cnt_model  = 0;
    endfunction

    task automatic step(input ins_t i, input logic r, output logic issued);
        exp_t e;
        logic act, c_hilo, c_br, c_ld;
        @(posedge clk);
        #1;
        k++;
        rst = r;
        id_valid = i.v; id_flush = i.fl; id_rs = i.rs; id_rt = i.rt;
        id_uses_rs = i.us; id_uses_rt = i.ut; id_is_branch = i.br;
        id_reg_write = i.rw; id_dest = i.dst; id_is_load = i.ld;
        id_is_muldiv = i.md; id_reads_hilo = i.rh;

        act    = i.v && !i.fl;
        c_hilo = act && (i.rh || i.md) && (k < hilo_ready);
        c_br   = act && i.br && ((i.us && i.rs != 0 && k < id_ready[i.rs]) ||
                                 (i.ut && i.rt != 0 && k < id_ready[i.rt]));
        c_ld   = act && !i.br && ((i.us && i.rs != 0 && k < ex_ready[i.rs]) ||
                                  (i.ut && i.rt != 0 && k < ex_ready[i.rt]));
        e.cause = c_hilo ? 2'd3 : c_br ? 2'd2 : c_ld ? 2'd1 : 2'd0;
        e.stall = (e.cause != 2'd0);
        e.mask  = '0;
        for (int g = 1; g < 32; g++) e.mask[g] = (k < id_ready[g]);
        e.count = cnt_model;
        q.push_back(e);

        issued = act && !e.stall && !r;
        if (r) begin
            model_clear();
        end else begin
            if (e.stall && cnt_model < (2 ** CNT_W) - 1) cnt_model++;
            if (issued && i.rw && i.dst != 0) begin
                ex_ready[i.dst] = i.ld ? k + 2 : k + 1;
                id_ready[i.dst] = k + 3;
            end
            if (issued && i.md) hilo_ready = k + MULT_LAT;
        end
    endtask

    // Present an instruction, holding it in ID while the model predicts a stall.
    task automatic issue_instr(input ins_t i);
        logic done;
        int   tries = 0;
        step(i, 1'b0, done);
        while (i.v && !i.fl && !done && tries < 20) begin
            step(i, 1'b0, done);
            tries++;
        end
    endtask

    task automatic nops(input int n);
        for (int j = 0; j < n; j++) issue_instr(f_nop());
    endtask

    function automatic void check(input string name, input longint got, input longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, k);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("stall",        stall,        e.stall);
                check("stall_cause",  stall_cause,  e.cause);
                check("pending_mask", pending_mask, e.mask);
                check("stall_count",  stall_count,  e.count);
            end
        end
    end

    initial begin : driver
        ins_t i;
        logic dummy;
        int   kind;
        rst = 1'b1;
        id_valid = 0; id_flush = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_is_branch = 0; id_reg_write = 0; id_dest = 0; id_is_load = 0;
        id_is_muldiv = 0; id_reads_hilo = 0;
        model_clear();
        repeat (2) @(posedge clk);

        nops(1);
        issue_instr(f_lw(5'd2, 5'd1));   issue_instr(f_alu(5'd3, 5'd2, 5'd4));   nops(3);
        issue_instr(f_alu(5'd5, 5'd1, 5'd1)); issue_instr(f_beq(5'd5, 5'd6));    nops(3);
        issue_instr(f_alu(5'd7, 5'd1, 5'd1)); issue_instr(f_sw(5'd1, 5'd7));     nops(3);
        issue_instr(f_mult(5'd1, 5'd2)); issue_instr(f_mflo(5'd9));              nops(3);
        issue_instr(f_lw(5'd0, 5'd1));   issue_instr(f_alu(5'd3, 5'd0, 5'd0));
        issue_instr(f_alu(5'd0, 5'd1, 5'd1)); issue_instr(f_beq(5'd0, 5'd0));    nops(3);
        issue_instr(f_lw(5'd10, 5'd1));
        i = f_alu(5'd11, 5'd10, 5'd10); i.fl = 1; issue_instr(i);                nops(3);
        issue_instr(f_lw(5'd8, 5'd1));   step(f_nop(), 1'b1, dummy);
        issue_instr(f_alu(5'd12, 5'd8, 5'd8));                                   nops(3);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                step(f_nop(), 1'b1, dummy);
                continue;
            end
            kind = $urandom_range(0, 7);
            case (kind)
                0: i = f_alu(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                1: i = f_lw(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                2: i = f_beq(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                3: i = f_sw(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                4: i = f_mult(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                5: i = f_mflo(5'($urandom_range(0, 7)));
                6: i = f_lw(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                default: i = f_nop();
            endcase
            if ($urandom_range(0, 7) == 0) i.fl = 1'b1;
            if ($urandom_range(0, 7) == 0) i.v = 1'b0;
            issue_instr(i);
        end

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d entries left want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
